// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared types, widths and divider helper for the UART blocks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    RECOVER = 3'd5
  } rx_state_t;

  // Truncating divide: system clocks per oversample tick.
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// Module  : uart_baud_tick
// Brief   : Free-running oversample tick divider with synchronous phase clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_frontend.sv
// ============================================================================
// Module  : uart_rx_frontend
// Brief   : Oversampled 8N1 UART receiver with start-bit validation.
//           Optional even-parity bit when UART_RX_PARITY_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rxd,
  output logic [UART_DATA_W-1:0] data,
  output logic                   data_valid,
  output logic                   frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                   parity_err,
`endif
  output logic                   busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(UART_DATA_W);
  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(UART_DATA_W - 1);

  logic sync1;
  logic sync2;
  logic rx_prev;
  logic rx_s;

  rx_state_t state;
  rx_state_t next_state;

  logic [SW-1:0]          scnt;
  logic [BW-1:0]          bit_cnt;
  logic [UART_DATA_W-1:0] shift;

  logic tick;
  logic start_edge;
  logic scnt_clr;
  logic scnt_inc;
  logic shift_en;
  logic load;
  logic ferr;

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic par_cap;
  logic perr;
  logic par_bad;
  assign par_bad = ^{shift, par_bit};
`endif

  // rxd is asynchronous; sync and edge-history flops idle high like the line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rxd;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

  assign rx_s       = sync2;
  assign start_edge = (state == IDLE) && rx_prev && !rx_s;
  assign busy       = (state != IDLE);

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (start_edge),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    scnt_clr   = 1'b0;
    scnt_inc   = 1'b0;
    shift_en   = 1'b0;
    load       = 1'b0;
    ferr       = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_cap    = 1'b0;
    perr       = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start_edge) begin
          next_state = START;
        end
      end
      START: begin
        if (tick) begin
          if (scnt == S_HALF) begin
            scnt_clr   = 1'b1;
            next_state = rx_s ? IDLE : DATA;
          end else begin
            scnt_inc = 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (scnt == S_LAST) begin
            scnt_clr = 1'b1;
            shift_en = 1'b1;
            if (bit_cnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
              next_state = PARITY;
`else
              next_state = STOP;
`endif
            end
          end else begin
            scnt_inc = 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (scnt == S_LAST) begin
            scnt_clr   = 1'b1;
            par_cap    = 1'b1;
            next_state = STOP;
          end else begin
            scnt_inc = 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (scnt == S_LAST) begin
            scnt_clr = 1'b1;
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
              perr = par_bad;
              load = !par_bad;
`else
              load = 1'b1;
`endif
              next_state = IDLE;
            end else begin
              // A bad stop bit outranks a parity mismatch.
              ferr       = 1'b1;
              next_state = RECOVER;
            end
          end else begin
            scnt_inc = 1'b1;
          end
        end
      end
      RECOVER: begin
        if (rx_s) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scnt    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      if (start_edge || scnt_clr) begin
        scnt <= '0;
      end else if (scnt_inc) begin
        scnt <= scnt + 1'b1;
      end

      if (start_edge) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (shift_en) begin
        shift <= {rx_s, shift[UART_DATA_W-1:1]};
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_cap) begin
        par_bit <= rx_s;
      end
      parity_err <= perr;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= load;
      frame_err  <= ferr;
      if (load) begin
        data <= shift;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frontend.sv
// ============================================================================
// Module  : tb_uart_rx_frontend
// Brief   : Self-checking bench for uart_rx_frontend (directed + random frames).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_frontend;

  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 1_562_500;
  localparam int OS       = 16;
  localparam int BIT      = CLK_FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    int         kind;   // 0 good byte, 1 frame error, 2 parity error
    logic [7:0] d;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  ev_t        ev_q[$];
  int         n_cmp;
  int         n_err;
  bit         both_seen;
  logic       busy_mid;
  logic [7:0] model_data;

  uart_rx_frontend #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid && frame_err) both_seen = 1'b1;
    if (data_valid) ev_q.push_back('{0, data});
    if (frame_err)  ev_q.push_back('{1, data});
`ifdef UART_RX_PARITY_EN
    if (parity_err) ev_q.push_back('{2, data});
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic flip);
    rxd = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      if (i == 0) begin
        wait_clks(BIT / 2);
        busy_mid = busy;
        wait_clks(BIT - BIT / 2);
      end else begin
        wait_clks(BIT);
      end
    end
    if (PAR_EN) begin
      rxd = (^b) ^ flip;
      wait_clks(BIT);
    end
    rxd = stop_bit;
    wait_clks(BIT);
    rxd = 1'b1;
  endtask

  // Reference: bad stop -> frame error; else bad parity -> parity error; else byte.
  task automatic expect_frame(input string tag, input logic [7:0] b,
                              input logic stop_bit, input logic flip);
    int ek;
    ek = !stop_bit ? 1 : ((PAR_EN && flip) ? 2 : 0);
    check({tag, "/count"}, ev_q.size(), 1);
    if (ev_q.size() > 0) begin
      check({tag, "/kind"}, ev_q[0].kind, ek);
      if (ek == 0) check({tag, "/byte"}, {24'd0, ev_q[0].d}, {24'd0, b});
    end
    if (ek == 0) model_data = b;
    check({tag, "/data"}, {24'd0, data}, {24'd0, model_data});
    ev_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    logic       sb;
    logic       fl;
    int         gap;

    n_cmp      = 0;
    n_err      = 0;
    both_seen  = 1'b0;
    busy_mid   = 1'b0;
    model_data = 8'h00;
    rst        = 1'b0;
    rxd        = 1'b1;
    wait_clks(5);
    check("reset/data", {24'd0, data}, 32'h00);
    check("reset/data_valid", {31'd0, data_valid}, 32'd0);
    check("reset/frame_err", {31'd0, frame_err}, 32'd0);
    check("reset/busy", {31'd0, busy}, 32'd0);
`ifdef UART_RX_PARITY_EN
    check("reset/parity_err", {31'd0, parity_err}, 32'd0);
`endif
    rst = 1'b1;
    wait_clks(10);

    // Single good byte
    send_frame(8'h55, 1'b1, 1'b0);
    expect_frame("t1_55", 8'h55, 1'b1, 1'b0);
    check("t1/busy_mid", {31'd0, busy_mid}, 32'd1);
    check("t1/busy_after", {31'd0, busy}, 32'd0);

    // Short low glitch on idle line
    rxd = 1'b0;
    wait_clks($urandom_range(1, 20));
    rxd = 1'b1;
    wait_clks(2 * BIT);
    check("t2/events", ev_q.size(), 0);
    check("t2/busy", {31'd0, busy}, 32'd0);

    // Bad stop bit
    send_frame(8'hA3, 1'b0, 1'b0);
    expect_frame("t3_A3", 8'hA3, 1'b0, 1'b0);
    wait_clks(BIT);
    check("t3/busy_after", {31'd0, busy}, 32'd0);

    // Long break gives exactly one frame error
    rxd = 1'b0;
    wait_clks(20 * BIT);
    rxd = 1'b1;
    wait_clks(BIT);
    check("t4/count", ev_q.size(), 1);
    if (ev_q.size() > 0) check("t4/kind", ev_q[0].kind, 1);
    check("t4/data", {24'd0, data}, {24'd0, model_data});
    check("t4/busy", {31'd0, busy}, 32'd0);
    ev_q.delete();
    send_frame(8'h0F, 1'b1, 1'b0);
    expect_frame("t4_0F", 8'h0F, 1'b1, 1'b0);

    // Back-to-back frames with no idle gap
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    check("t5/count", ev_q.size(), 2);
    if (ev_q.size() == 2) begin
      check("t5/kind0", ev_q[0].kind, 0);
      check("t5/byte0", {24'd0, ev_q[0].d}, 32'h00);
      check("t5/kind1", ev_q[1].kind, 0);
      check("t5/byte1", {24'd0, ev_q[1].d}, 32'hFF);
    end
    model_data = 8'hFF;
    check("t5/data", {24'd0, data}, 32'hFF);
    ev_q.delete();
    wait_clks(BIT);

    // Reset in the middle of a byte
    rxd = 1'b0;
    wait_clks(BIT);
    rxd = 1'b0;
    wait_clks(BIT);
    rxd = 1'b1;
    wait_clks(BIT + BIT / 3);
    rst = 1'b0;
    #1;
    check("t6/rst_data", {24'd0, data}, 32'h00);
    check("t6/rst_busy", {31'd0, busy}, 32'd0);
    check("t6/rst_dv", {31'd0, data_valid}, 32'd0);
    model_data = 8'h00;
    rxd = 1'b1;
    wait_clks(5);
    rst = 1'b1;
    wait_clks(BIT);
    check("t6/no_event", ev_q.size(), 0);
    send_frame(8'h3C, 1'b1, 1'b0);
    expect_frame("t6_3C", 8'h3C, 1'b1, 1'b0);

    if (PAR_EN) begin
      send_frame(8'h5A, 1'b1, 1'b1);
      expect_frame("par_bad", 8'h5A, 1'b1, 1'b1);
      send_frame(8'h96, 1'b0, 1'b1);
      expect_frame("par_bad_stop", 8'h96, 1'b0, 1'b1);
      wait_clks(BIT);
    end

    // Random frames
    for (int k = 0; k < 24; k++) begin
      b   = 8'($urandom);
      sb  = ($urandom_range(0, 4) != 0);
      fl  = PAR_EN && ($urandom_range(0, 3) == 0);
      send_frame(b, sb, fl);
      expect_frame($sformatf("rnd%0d", k), b, sb, fl);
      gap = sb ? $urandom_range(0, 2) : $urandom_range(1, 2);
      if (gap > 0) begin
        wait_clks(gap * BIT);
        check($sformatf("rnd%0d/busy", k), {31'd0, busy}, 32'd0);
      end
    end

    check("never_both", {31'd0, both_seen}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
